vga_scan_driver: RTL

- Raster timing generator and pixel output stage that sits on the display side of the game renderer.
- Produces the pixel coordinates that the renderer consumes.
- Samples the renderer's RGB after a fixed pipeline latency, then drives VGA sync, blank and colour pins with all signals mutually aligned.
- Emits a once-per-frame tick, so game-state logic can update during vertical blanking.

---
 rtl/vga_scan_driver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster timing generator plus aligned VGA pixel output stage.
// Issues pixel coordinates to the renderer. Delays the sync and active terms
// so they line up with the renderer's RGB. Registers everything at the pins.
module vga_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        iRST,
  input  logic        iPix_en,
  output logic [12:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  output logic        oActive,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N,
  output logic        oFrame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_LAST     = 13'(H_TOTAL - 1);
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  // Last visible line; wrapping out of it starts vertical blanking.
  localparam logic [10:0] V_TICK_ROW = 11'(V_ACTIVE - 1);

  // Level driven on a sync pin while its sync term is asserted.
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [12:0] h_cnt_reg;
  logic [10:0] v_cnt_reg;
  logic        h_wrap;
  logic        v_wrap;
  logic        active_now;
  logic        hs_raw;
  logic        vs_raw;

  // Pipeline stage bits: [2] = hs, [1] = vs, [0] = active.
  logic [2:0]  pipe_reg [PIPE_LAT];
  logic [2:0]  pipe_tail;

  logic [7:0]  red_reg;
  logic [7:0]  green_reg;
  logic [7:0]  blue_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic        blank_n_reg;
  logic        tick_reg;

  assign h_wrap     = (h_cnt_reg == H_LAST);
  assign v_wrap     = (v_cnt_reg == V_LAST);
  assign active_now = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
  assign hs_raw     = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
  assign vs_raw     = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
  assign pipe_tail  = pipe_reg[PIPE_LAT-1];

  // Raster counters: h wraps each line, v steps on every h wrap.
  always_ff @(posedge clk) begin
    if (iRST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (iPix_en) begin
      if (h_wrap) begin
        h_cnt_reg <= '0;
        if (v_wrap) begin
          v_cnt_reg <= '0;
        end else begin
          v_cnt_reg <= v_cnt_reg + 11'd1;
        end
      end else begin
        h_cnt_reg <= h_cnt_reg + 13'd1;
      end
    end
  end

  // Delay line that keeps sync/active in step with the renderer's RGB latency.
  always_ff @(posedge clk) begin
    if (iRST) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_reg[i] <= 3'b000;
      end
    end else if (iPix_en) begin
      pipe_reg[0] <= {hs_raw, vs_raw, active_now};
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  // Pin register stage: polarity mapping and colour blanking.
  always_ff @(posedge clk) begin
    if (iRST) begin
      red_reg     <= 8'd0;
      green_reg   <= 8'd0;
      blue_reg    <= 8'd0;
      hs_reg      <= ~SYNC_ON;
      vs_reg      <= ~SYNC_ON;
      blank_n_reg <= 1'b0;
    end else if (iPix_en) begin
      hs_reg      <= pipe_tail[2] ? SYNC_ON : ~SYNC_ON;
      vs_reg      <= pipe_tail[1] ? SYNC_ON : ~SYNC_ON;
      blank_n_reg <= pipe_tail[0];
      red_reg     <= pipe_tail[0] ? iRed   : 8'd0;
      green_reg   <= pipe_tail[0] ? iGreen : 8'd0;
      blue_reg    <= pipe_tail[0] ? iBlue  : 8'd0;
    end
  end

  // Single-cycle frame tick on the edge that moves into the first blank line.
  always_ff @(posedge clk) begin
    if (iRST) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= iPix_en && h_wrap && (v_cnt_reg == V_TICK_ROW);
    end
  end

  assign oCoord_X     = h_cnt_reg;
  assign oCoord_Y     = v_cnt_reg;
  assign oActive      = active_now;
  assign oVGA_R       = red_reg;
  assign oVGA_G       = green_reg;
  assign oVGA_B       = blue_reg;
  assign oVGA_HS      = hs_reg;
  assign oVGA_VS      = vs_reg;
  assign oVGA_BLANK_N = blank_n_reg;
  assign oVGA_SYNC_N  = 1'b0;
  assign oFrame_tick  = tick_reg;

endmodule
